adaptor2x2_mem_master: RTL and testbench

ADAPTOR2X2_MEM_MASTER -- requirements
Module: adaptor2x2_mem_master

---
 rtl/adaptor2x2_mem_master.sv | 175 +++++++++++++++++
 tb/tb_adaptor2x2_mem_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adaptor2x2_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : adaptor2x2_mem_master
// Purpose  : Command-driven DMA-style master between two streams and a
//            single-port synchronous memory. A write job copies words from the
//            wr_* stream into memory; a read job copies words from memory into
//            the rd_* stream through a 2-entry output buffer.
// Ports    : clk, reset_n            - clock, async active-low reset
//            cmd_*                   - job request (valid/ready, dir, addr, len)
//            wr_valid/ready/data     - write-data stream (sink)
//            rd_valid/ready/data     - read-data stream (source)
//            av_*                    - memory port (1-cycle read latency)
//            busy, done              - job in progress / end-of-job pulse
// Revision : 1.0 - initial release
// ============================================================================
module adaptor2x2_mem_master #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [ADDR_W-1:0]   cmd_len,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [DATA_W-1:0]   wr_data,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [DATA_W-1:0]   rd_data,
   output logic [ADDR_W-1:0]   av_address,
   output logic                av_chipselect,
   output logic                av_write,
   output logic [DATA_W/8-1:0] av_byteenable,
   output logic [DATA_W-1:0]   av_writedata,
   output logic                av_clken,
   input  logic [DATA_W-1:0]   av_readdata,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
   localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   // Counters are one bit wider than the address so a length of 0 can mean 2^ADDR_W.
   logic [ADDR_W:0]     remain_q, remain_d;   // words still to write / issue
   logic [ADDR_W:0]     pops_q, pops_d;       // read words still to hand out
   logic                inflight_q, inflight_d;
   logic [DATA_W-1:0]   mem_q [2];
   logic [DATA_W-1:0]   mem_d [2];
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          count_q, count_d;

   logic                w_pop;
   logic                w_push;
   logic                w_issue;
   logic                w_wbeat;
   logic [2:0]          w_occ;

   assign rd_valid      = (count_q != 2'd0);
   assign rd_data       = mem_q[rd_ptr_q];
   assign w_pop         = rd_valid & rd_ready;
   assign w_push        = inflight_q;
   // Occupancy the buffer will have once this cycle's pop and last cycle's
   // issue have settled; a new read may only go out if it still has a slot.
   assign w_occ         = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
   assign w_issue       = (state_q == S_READ) && (remain_q != '0) && (w_occ < 3'd2);
   assign w_wbeat       = (state_q == S_WRITE) && wr_valid;

   // Qualified with reset_n so the port reads not-ready while reset is held.
   assign cmd_ready     = reset_n && (state_q == S_IDLE);
   assign wr_ready      = (state_q == S_WRITE);
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign av_address    = addr_q;
   assign av_chipselect = w_wbeat | w_issue;
   assign av_write      = w_wbeat;
   assign av_writedata  = wr_data;
   assign av_byteenable = '1;
   assign av_clken      = 1'b1;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      pops_d     = pops_q;
      inflight_d = w_issue;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + {1'b0, w_push} - {1'b0, w_pop};

      if (w_push) begin
         mem_d[wr_ptr_q] = av_readdata;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (w_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d   = cmd_addr;
               remain_d = {(cmd_len == '0), cmd_len};
               pops_d   = {(cmd_len == '0), cmd_len};
               state_d  = cmd_write ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            if (wr_valid) begin
               addr_d   = addr_q + c_addr_one;
               remain_d = remain_q - c_cnt_one;
               if (remain_q == c_cnt_one) begin
                  state_d = S_DONE;
               end
            end
         end
         S_READ: begin
            if (w_issue) begin
               addr_d   = addr_q + c_addr_one;
               remain_d = remain_q - c_cnt_one;
            end
            if (w_pop) begin
               pops_d = pops_q - c_cnt_one;
               if (pops_q == c_cnt_one) begin
                  state_d = S_DONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         pops_q     <= '0;
         inflight_q <= 1'b0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         pops_q     <= pops_d;
         inflight_q <= inflight_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adaptor2x2_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_adaptor2x2_mem_master
// Purpose  : Directed self-checking bench for adaptor2x2_mem_master with a
//            1024-word memory model of 1-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adaptor2x2_mem_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [9:0]  cmd_addr, cmd_len;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_data;
   logic        rd_valid, rd_ready;
   logic [31:0] rd_data;
   logic [9:0]  av_address;
   logic        av_chipselect, av_write, av_clken;
   logic [3:0]  av_byteenable;
   logic [31:0] av_writedata, av_readdata;
   logic        busy, done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mem [1024];

   always #5 clk = ~clk;

   adaptor2x2_mem_master #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .av_address(av_address), .av_chipselect(av_chipselect), .av_write(av_write),
      .av_byteenable(av_byteenable), .av_writedata(av_writedata),
      .av_clken(av_clken), .av_readdata(av_readdata),
      .busy(busy), .done(done)
   );

   // Memory model: synchronous write, read data one cycle after the address.
   always @(posedge clk) begin
      if (av_chipselect && av_write) mem[av_address] <= av_writedata;
      if (av_chipselect && !av_write) av_readdata <= mem[av_address];
   end

   function automatic logic [31:0] fill(input int i);
      return 32'h5A00_0000 ^ 32'(i);
   endfunction

   // Presents a command for one clock and returns at the negedge after acceptance.
   task automatic send_cmd(input logic wr, input logic [9:0] a, input logic [9:0] l);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); else n_pass++;
      n_checks++; if (wr_ready !== 1'b0) $display("FAIL rst_wr_ready got %b exp 0", wr_ready); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %b exp 0", rd_valid); else n_pass++;
      n_checks++; if ({av_chipselect, av_write} !== 2'b00) $display("FAIL rst_av_cs_wr got %b exp 00", {av_chipselect, av_write}); else n_pass++;
      n_checks++; if (av_address !== 10'h000) $display("FAIL rst_av_address got %h exp 000", av_address); else n_pass++;
      n_checks++; if ({busy, done} !== 2'b00) $display("FAIL rst_busy_done got %b exp 00", {busy, done}); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready got %b exp 1", cmd_ready); else n_pass++;
      n_checks++; if (av_byteenable !== 4'hF) $display("FAIL byteenable got %h exp f", av_byteenable); else n_pass++;
      n_checks++; if (av_clken !== 1'b1) $display("FAIL clken got %b exp 1", av_clken); else n_pass++;
   endtask

   task automatic test_write(input logic [9:0] a, input int len, input logic [31:0] d0);
      logic [9:0] ea;
      send_cmd(1'b1, a, 10'(len));
      for (int i = 0; i < len; i++) begin
         if (i > 0) @(negedge clk);
         wr_valid = 1'b1; wr_data = d0 + 32'(i);
         ea = a + 10'(i);
         #1;
         n_checks++; if ({av_chipselect, av_write, wr_ready, busy} !== 4'b1111)
            $display("FAIL wr_strobes beat %0d got %b exp 1111", i, {av_chipselect, av_write, wr_ready, busy}); else n_pass++;
         n_checks++; if (av_address !== ea) $display("FAIL wr_addr beat %0d got %h exp %h", i, av_address, ea); else n_pass++;
         n_checks++; if (av_writedata !== d0 + 32'(i)) $display("FAIL wr_data beat %0d got %h exp %h", i, av_writedata, d0 + 32'(i)); else n_pass++;
      end
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      n_checks++; if ({done, av_chipselect} !== 2'b10) $display("FAIL wr_done got %b exp 10", {done, av_chipselect}); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if ({done, busy, cmd_ready} !== 3'b001) $display("FAIL wr_idle got %b exp 001", {done, busy, cmd_ready}); else n_pass++;
      for (int i = 0; i < len; i++) begin
         ea = a + 10'(i);
         n_checks++; if (mem[ea] !== d0 + 32'(i)) $display("FAIL wr_mem %h got %h exp %h", ea, mem[ea], d0 + 32'(i)); else n_pass++;
      end
   endtask

   // Expects 0x010..0x013 to hold 0xA0..0xA3.
   task automatic test_read_stream();
      send_cmd(1'b0, 10'h010, 10'd4);
      rd_ready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h200; cmd_len = 10'd1;
      #1;
      n_checks++; if ({rd_valid, av_chipselect, av_write, cmd_ready} !== 4'b0100)
         $display("FAIL rd_first_issue got %b exp 0100", {rd_valid, av_chipselect, av_write, cmd_ready}); else n_pass++;
      n_checks++; if (av_address !== 10'h010) $display("FAIL rd_first_addr got %h exp 010", av_address); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL rd_latency got %b exp 0", rd_valid); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 2) cmd_valid = 1'b0;
         #1;
         n_checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hA0 + 32'(i))
            $display("FAIL rd_word %0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 32'hA0 + 32'(i)); else n_pass++;
      end
      @(negedge clk);
      #1;
      n_checks++; if ({done, rd_valid} !== 2'b10) $display("FAIL rd_done got %b exp 10", {done, rd_valid}); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if ({done, busy, cmd_ready} !== 3'b001) $display("FAIL rd_idle got %b exp 001", {done, busy, cmd_ready}); else n_pass++;
      rd_ready = 1'b0;
   endtask

   task automatic test_read_toggle();
      logic [31:0] got [4];
      int issued = 0, pops = 0, dones = 0, max_out = 0;
      bit stall = 1'b0, fin = 1'b0;
      send_cmd(1'b0, 10'h010, 10'd4);
      for (int c = 0; c < 60 && !fin; c++) begin
         if (c > 0) @(negedge clk);
         rd_ready = c[0];
         #1;
         if (av_chipselect && !av_write) issued++;
         else if (busy && !done && issued < 4) stall = 1'b1;
         if (rd_valid && rd_ready) begin
            if (pops < 4) got[pops] = rd_data;
            pops++;
         end
         if (issued - pops > max_out) max_out = issued - pops;
         if (done) begin dones++; fin = 1'b1; end
      end
      rd_ready = 1'b0;
      n_checks++; if (fin !== 1'b1) $display("FAIL tog_timeout got %b exp 1", fin); else n_pass++;
      n_checks++; if (pops !== 4 || issued !== 4) $display("FAIL tog_counts got pops=%0d issued=%0d exp 4/4", pops, issued); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (got[i] !== 32'hA0 + 32'(i)) $display("FAIL tog_word %0d got %h exp %h", i, got[i], 32'hA0 + 32'(i)); else n_pass++;
      end
      n_checks++; if (max_out > 2) $display("FAIL tog_overfill got %0d exp <=2", max_out); else n_pass++;
      n_checks++; if (stall !== 1'b1) $display("FAIL tog_cs_stall got %b exp 1", stall); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if ({dones[1:0], cmd_ready, busy} !== 4'b0110) $display("FAIL tog_end got %b exp 0110", {dones[1:0], cmd_ready, busy}); else n_pass++;
   endtask

   task automatic test_len0();
      int bad_w = 0, bad_a = 0, bad_d = 0, issued = 0, pops = 0, dones = 0;
      send_cmd(1'b1, 10'h000, 10'd0);
      wr_valid = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         wr_data = fill(i);
         #1;
         if (!(av_write && av_address == 10'(i))) bad_w++;
         @(negedge clk);
      end
      wr_valid = 1'b0;
      #1;
      n_checks++; if (bad_w !== 0 || done !== 1'b1) $display("FAIL len0_write got bad=%0d done=%b exp 0/1", bad_w, done); else n_pass++;
      send_cmd(1'b0, 10'h000, 10'd0);
      rd_ready = 1'b1;
      for (int c = 0; c < 1060; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (av_chipselect && !av_write) begin
            if (av_address !== 10'(issued)) bad_a++;
            issued++;
         end
         if (rd_valid) begin
            if (rd_data !== fill(pops)) bad_d++;
            pops++;
         end
         if (done) dones++;
      end
      rd_ready = 1'b0;
      n_checks++; if (issued !== 1024 || pops !== 1024) $display("FAIL len0_counts got issued=%0d pops=%0d exp 1024", issued, pops); else n_pass++;
      n_checks++; if (bad_a !== 0) $display("FAIL len0_addr got %0d bad exp 0", bad_a); else n_pass++;
      n_checks++; if (bad_d !== 0) $display("FAIL len0_data got %0d bad exp 0", bad_d); else n_pass++;
      n_checks++; if (dones !== 1) $display("FAIL len0_done_pulses got %0d exp 1", dones); else n_pass++;
   endtask

   // Runs after test_len0, so 0x101 still holds its fill pattern.
   task automatic test_reset_mid();
      send_cmd(1'b1, 10'h100, 10'd8);
      wr_valid = 1'b1; wr_data = 32'hC0;
      @(negedge clk);
      wr_data = 32'hC1;
      #1;
      n_checks++; if (av_write !== 1'b1) $display("FAIL mid_second_beat got %b exp 1", av_write); else n_pass++;
      reset_n = 1'b0;
      #1;
      n_checks++; if ({av_write, av_chipselect, busy, wr_ready, cmd_ready} !== 5'b00000)
         $display("FAIL mid_abort got %b exp 00000", {av_write, av_chipselect, busy, wr_ready, cmd_ready}); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1; wr_valid = 1'b0;
      #1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL mid_release_ready got %b exp 1", cmd_ready); else n_pass++;
      send_cmd(1'b0, 10'h100, 10'd2);
      rd_ready = 1'b1;
      #1;
      n_checks++; if (busy !== 1'b1) $display("FAIL mid_new_cmd got %b exp 1", busy); else n_pass++;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (rd_data !== 32'hC0 || rd_valid !== 1'b1) $display("FAIL mid_word0 got %h exp c0", rd_data); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if (rd_data !== fill(32'h101) || rd_valid !== 1'b1) $display("FAIL mid_word1 got %h exp %h", rd_data, fill(32'h101)); else n_pass++;
      @(negedge clk);
      #1;
      n_checks++; if (done !== 1'b1) $display("FAIL mid_done got %b exp 1", done); else n_pass++;
      rd_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      test_reset();
      test_write(10'h010, 4, 32'hA0);
      test_read_stream();
      test_read_toggle();
      test_write(10'h3FE, 3, 32'hB0);
      test_len0();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
